// File: rtl/tnn_serial_threshold_neuron.sv
// Serial threshold neuron: one channel is added per clock, then the block flags sum >= threshold.
// Defining TNN_TRUNC_EN drops the TRUNC LSBs of every channel before it is added (approximate mode).
module tnn_serial_threshold_neuron #(
    parameter  int unsigned N_IN  = 5,
    parameter  int unsigned W     = 3,
    parameter  int unsigned TRUNC = 1,
    localparam int unsigned ACC_W = W + $clog2(N_IN) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_IN*W-1:0]   in_data,
    input  logic [ACC_W-1:0]    in_thr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_bit,
    output logic [ACC_W-1:0]    out_sum
);

    localparam int unsigned CNT_W = $clog2(N_IN);
`ifdef TNN_TRUNC_EN
    localparam bit TRUNC_EN = 1'b1;
`else
    localparam bit TRUNC_EN = 1'b0;
`endif
    localparam int unsigned   DROP    = TRUNC_EN ? TRUNC : 0;
    localparam logic [W-1:0]  CH_MASK = {W{1'b1}} << DROP;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t              state_q;
    logic [N_IN*W-1:0]   data_q;
    logic [ACC_W-1:0]    thr_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [W-1:0]        chan;
    logic [W-1:0]        chan_m;
    logic                last;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                out_bit_q;
    logic [ACC_W-1:0]    out_sum_q;

    always_comb begin
        chan = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                chan = data_q[k*W +: W];
            end
        end
        chan_m = chan & CH_MASK;
        acc_d  = acc_q + {{(ACC_W-W){1'b0}}, chan_m};
        last   = (cnt_q == CNT_W'(N_IN - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            thr_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        thr_q      <= in_thr;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ACC;
                    end
                end
                ACC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // The decision uses acc_d so the result lands on the same edge as the last add.
                    if (last) begin
                        cnt_q       <= '0;
                        out_sum_q   <= acc_d;
                        out_bit_q   <= (acc_d >= thr_q);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_tnn_serial_threshold_neuron.sv
// Self-checking bench for tnn_serial_threshold_neuron: directed cases plus random vectors
// with random output stalls, compared against an arithmetic sum >= threshold model.
module tb_tnn_serial_threshold_neuron;

    localparam int unsigned N     = 5;
    localparam int unsigned W     = 3;
    localparam int unsigned TRUNC = 1;
    localparam int unsigned AW    = W + $clog2(N) + 1;
    localparam int unsigned DW    = N * W;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_thr;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic [AW-1:0] out_sum;

    int checks   = 0;
    int failures = 0;

    tnn_serial_threshold_neuron #(.N_IN(N), .W(W), .TRUNC(TRUNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_thr    (in_thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_sum(input logic [DW-1:0] d);
        int s = 0;
        for (int k = 0; k < N; k++) begin
            int c = int'((d >> (k * W)) % (1 << W));
`ifdef TNN_TRUNC_EN
            c = (c >> TRUNC) << TRUNC;
`endif
            s += c;
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] pack(input int a0, input int a1, input int a2,
                                           input int a3, input int a4);
        logic [DW-1:0] d;
        d = '0;
        d[0*W +: W] = W'(a0);
        d[1*W +: W] = W'(a1);
        d[2*W +: W] = W'(a2);
        d[3*W +: W] = W'(a3);
        d[4*W +: W] = W'(a4);
        return d;
    endfunction

    // Runs one vector end to end; call at a negedge with out_ready low.
    task automatic run_vec(input logic [DW-1:0] d, input logic [AW-1:0] t, input int stall);
        int n;
        int lat;
        int exp_sum;
        logic [AW-1:0] s_hold;
        logic          b_hold;
        exp_sum = model_sum(d);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_thr   = t;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_thr   = AW'($urandom);
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            in_data = DW'($urandom);
            in_thr  = AW'($urandom);
        end
        chk("latency", 32'(lat), 32'(N));
        chk("out_sum", 32'(out_sum), 32'(exp_sum));
        chk("out_bit", 32'(out_bit), 32'(exp_sum >= int'(t)));
        s_hold = out_sum;
        b_hold = out_bit;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
            in_thr   = AW'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(out_sum), 32'(s_hold));
            chk("stall_bit", 32'(out_bit), 32'(b_hold));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] d;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_thr    = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bit", 32'(out_bit), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec(pack(7, 7, 7, 7, 7), AW'(9), 0);
        chk("t1_sum_const", 32'(out_sum), 32'(model_sum(pack(7, 7, 7, 7, 7))));
        run_vec(pack(0, 0, 0, 0, 0), AW'(1), 0);
        chk("t2_bit_thr1", 32'(out_bit), 32'd0);
        run_vec(pack(0, 0, 0, 0, 0), AW'(0), 1);
        chk("t2_bit_thr0", 32'(out_bit), 32'd1);
        run_vec(pack(1, 2, 3, 1, 2), AW'(9), 0);
        run_vec(pack(1, 2, 3, 1, 2), AW'(10), 0);
        run_vec(pack(3, 5, 6, 2, 4), AW'(12), 4);

        // Reset in the middle of accumulation aborts the vector.
        in_valid = 1'b1;
        in_data  = pack(7, 7, 7, 7, 7);
        in_thr   = AW'(1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_bit", 32'(out_bit), 32'd0);
        chk("abort_out_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_vec(pack(7, 0, 0, 0, 0), AW'(7), 0);
        chk("t5_bit", 32'(out_bit), 32'd1);

        run_vec(pack(1, 1, 1, 1, 1), AW'(1), 0);
`ifdef TNN_TRUNC_EN
        chk("t6_trunc_sum", 32'(out_sum), 32'd0);
        chk("t6_trunc_bit", 32'(out_bit), 32'd0);
`else
        chk("t6_exact_sum", 32'(out_sum), 32'd5);
        chk("t6_exact_bit", 32'(out_bit), 32'd1);
`endif

        for (int v = 0; v < 2000; v++) begin
            d = DW'($urandom);
            run_vec(d, AW'($urandom_range(0, 40)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
